// File: rtl/monociclo_pkg.sv
// Shared definitions for the single-cycle core run controller.
// State encodings, default timing constants and a counter-width helper.
package monociclo_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_t;

  localparam int unsigned DEF_DIV_COUNT       = 25_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/monociclo_run_ctrl_debounce_pulse.sv
// Step button conditioning: 2-flop synchronizer, debounce filter and
// a one-cycle pulse on each accepted press.
module debounce_pulse
  import monociclo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW:0] LIM = (CW+1)'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_nxt;
  logic [1:0]    prime;
  logic          armed;

  assign cnt_nxt = {1'b0, cnt} + (CW+1)'(1);

  // A press is only honoured once the button has been seen released
  // after reset, so a button held through reset cannot step the core.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
      prime   <= '0;
      armed   <= 1'b0;
    end else begin
      sync1  <= raw_i;
      sync2  <= sync1;
      prime  <= {prime[0], 1'b1};
      rise_o <= 1'b0;
      if (prime[1] && !level_o && !sync2)
        armed <= 1'b1;
      if (sync2 == level_o) begin
        cnt <= '0;
      end else if (cnt_nxt == LIM) begin
        level_o <= sync2;
        cnt     <= '0;
        rise_o  <= sync2 & armed;
      end else begin
        cnt <= cnt_nxt[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/monociclo_run_ctrl.sv
// Run controller: issues single-cycle clock enables to the core in
// free-run, single-step or breakpoint-halted operation.
module monociclo_run_ctrl
  import monociclo_pkg::*;
#(
  parameter int unsigned DIV_COUNT       = DEF_DIV_COUNT,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned W               = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         run_mode_i,
  input  logic         step_btn_i,
  input  logic         bkpt_en_i,
  input  logic [W-1:0] bkpt_addr_i,
  input  logic [W-1:0] pc_i,
  output logic         cpu_en_o,
  output logic         halted_o,
  output logic         bkpt_hit_o,
  output logic [1:0]   state_o,
  output logic [W-1:0] cycle_cnt_o
);

  localparam int unsigned TW = cnt_w(DIV_COUNT);
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV_COUNT - 1);

  run_state_t    state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          bkpt_match;
  logic          btn_level;
  logic          btn_rise;
  logic          step_req;

  debounce_pulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .raw_i  (step_btn_i),
    .level_o(btn_level),
    .rise_o (btn_rise)
  );

  assign step_req   = btn_rise & btn_level;
  assign tick       = (tick_cnt == TICK_MAX);
  assign bkpt_match = bkpt_en_i && (pc_i == bkpt_addr_i);

  // Tick counter defaults to 0 so it restarts cleanly on every RUN entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_HALT;
      cpu_en_o    <= 1'b0;
      cycle_cnt_o <= '0;
      tick_cnt    <= '0;
    end else begin
      cpu_en_o <= 1'b0;
      tick_cnt <= '0;
      if (cpu_en_o)
        cycle_cnt_o <= cycle_cnt_o + W'(1);
      unique case (state)
        ST_HALT: begin
          if (run_mode_i) begin
            state <= ST_RUN;
          end else if (step_req) begin
            state    <= ST_STEP;
            cpu_en_o <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!run_mode_i)
            state <= ST_HALT;
          else if (tick && bkpt_match)
            state <= ST_BREAK;
          else if (tick)
            cpu_en_o <= 1'b1;
          else
            tick_cnt <= tick_cnt + TW'(1);
        end
        ST_STEP: begin
          state <= ST_HALT;
        end
        ST_BREAK: begin
          if (step_req) begin
            state    <= ST_STEP;
            cpu_en_o <= 1'b1;
          end else if (!run_mode_i) begin
            state <= ST_HALT;
          end
        end
      endcase
    end
  end

  assign halted_o   = (state == ST_HALT) || (state == ST_BREAK);
  assign bkpt_hit_o = (state == ST_BREAK);
  assign state_o    = state;

endmodule

// File: tb/tb_monociclo_run_ctrl.sv
// Scoreboard bench for monociclo_run_ctrl: expected enable pulses are
// queued by the stimulus and retired by an independent monitor.
module tb_monociclo_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        run_mode_i;
  logic        step_btn_i;
  logic        bkpt_en_i;
  logic [31:0] bkpt_addr_i;
  logic [31:0] pc_i;
  logic        cpu_en_o;
  logic        halted_o;
  logic        bkpt_hit_o;
  logic [1:0]  state_o;
  logic [31:0] cycle_cnt_o;

  always #5 clk = ~clk;

  monociclo_run_ctrl #(
    .DIV_COUNT      (4),
    .DEBOUNCE_CYCLES(3),
    .W              (32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .run_mode_i (run_mode_i),
    .step_btn_i (step_btn_i),
    .bkpt_en_i  (bkpt_en_i),
    .bkpt_addr_i(bkpt_addr_i),
    .pc_i       (pc_i),
    .cpu_en_o   (cpu_en_o),
    .halted_o   (halted_o),
    .bkpt_hit_o (bkpt_hit_o),
    .state_o    (state_o),
    .cycle_cnt_o(cycle_cnt_o)
  );

  typedef struct {
    int          at;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   c;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cpu_en_o === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: pulse at cycle %0d, none expected",
                 cyc);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.at != cyc || cycle_cnt_o !== mon_e.cnt) begin
          errors++;
          $display("FAIL pulse: cycle %0d cnt %0d, expected cycle %0d cnt %0d",
                   cyc, cycle_cnt_o, mon_e.at, mon_e.cnt);
        end
      end
    end
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int at, input logic [31:0] cnt);
    exp_t e;
    e.at  = at;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [1:0] st,
                           input logic [31:0] cnt);
    @(negedge clk);
    chk({name, "_state"}, 32'(state_o), 32'(st));
    chk({name, "_cnt"}, cycle_cnt_o, cnt);
  endtask

  logic bounce [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                        1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_i       = 1'b1;
    run_mode_i  = 1'b0;
    step_btn_i  = 1'b0;
    bkpt_en_i   = 1'b0;
    bkpt_addr_i = '0;
    pc_i        = '0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_halted", 32'(halted_o), 32'd1);
    chk("rst_cpu_en", 32'(cpu_en_o), 32'd0);
    chk("rst_cnt", cycle_cnt_o, 32'd0);
    chk("rst_bkpt", 32'(bkpt_hit_o), 32'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    go(5);

    // bouncing button: no step
    for (int i = 0; i < 10; i++) begin
      step_btn_i = bounce[i];
      go(1);
    end
    go(6);
    chk_state("bounce", 2'd0, 32'd0);

    // clean press: one step
    go(1);
    c = cyc;
    expect_pulse(c + 6, 32'd0);
    step_btn_i = 1'b1;
    go(10);
    step_btn_i = 1'b0;
    go(8);
    chk_state("step", 2'd0, 32'd1);

    // free run
    go(1);
    c = cyc;
    expect_pulse(c + 5, 32'd1);
    expect_pulse(c + 9, 32'd2);
    expect_pulse(c + 13, 32'd3);
    expect_pulse(c + 17, 32'd4);
    run_mode_i = 1'b1;
    go(18);
    bkpt_en_i   = 1'b1;
    bkpt_addr_i = 32'h0000_0010;
    pc_i        = 32'h0000_0010;
    chk_state("run", 2'd1, 32'd5);

    // breakpoint hit at next tick
    go(4);
    chk_state("bkpt", 2'd3, 32'd5);
    chk("bkpt_hit", 32'(bkpt_hit_o), 32'd1);
    chk("bkpt_halted", 32'(halted_o), 32'd1);

    // step out of breakpoint, then resume running
    go(1);
    c = cyc;
    expect_pulse(c + 6, 32'd5);
    expect_pulse(c + 12, 32'd6);
    expect_pulse(c + 16, 32'd7);
    step_btn_i = 1'b1;
    pc_i       = 32'h0000_0014;
    go(6);
    chk_state("bk_step", 2'd2, 32'd5);
    go(1);
    chk_state("bk_halt", 2'd0, 32'd6);
    go(1);
    step_btn_i = 1'b0;
    chk_state("bk_run", 2'd1, 32'd6);

    // drop run on the same edge as a tick
    go(11);
    run_mode_i = 1'b0;
    go(3);
    chk_state("stop", 2'd0, 32'd8);
    chk("stop_cpu_en", 32'(cpu_en_o), 32'd0);

    // reset mid-run
    rst_i = 1'b1;
    go(1);
    rst_i     = 1'b0;
    bkpt_en_i = 1'b0;
    go(1);
    c = cyc;
    expect_pulse(c + 5, 32'd0);
    expect_pulse(c + 9, 32'd1);
    expect_pulse(c + 13, 32'd2);
    run_mode_i = 1'b1;
    go(14);
    rst_i = 1'b1;
    chk_state("pre_rst", 2'd1, 32'd3);
    go(1);
    run_mode_i = 1'b0;
    chk_state("mid_rst", 2'd0, 32'd0);
    chk("mid_rst_cpu_en", 32'(cpu_en_o), 32'd0);

    // button held through reset must not step
    step_btn_i = 1'b1;
    go(2);
    rst_i = 1'b0;
    go(12);
    chk_state("held", 2'd0, 32'd0);
    go(1);
    step_btn_i = 1'b0;
    go(8);
    c = cyc;
    expect_pulse(c + 6, 32'd0);
    step_btn_i = 1'b1;
    go(10);
    step_btn_i = 1'b0;
    go(6);
    chk_state("repress", 2'd0, 32'd1);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d pending, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
